// File: rtl/fpu_norm_shift_128.sv
// Two-stage leading-one normaliser for 128-bit FPU mantissas.
// Define FPU_NORM_DENORM_CLAMP_EN to clamp the shift at EMIN (subnormal results).
module lzc_128 (
  input  logic [127:0] a_i,
  output logic [6:0]   idx_o,
  output logic         valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < 128; i++) begin
      if (a_i[i]) begin
        idx_o   = 7'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

module fpu_norm_shift_128 #(
  parameter int EXP_W = 16,
  parameter int EMIN  = -16382
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_mant,
  input  logic [EXP_W-1:0] in_exp,
  input  logic             in_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_mant,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_sign,
  output logic             out_zero
);

`ifdef FPU_NORM_DENORM_CLAMP_EN
  localparam bit ClampEn = 1'b1;
`else
  localparam bit ClampEn = 1'b0;
`endif

  localparam logic signed [EXP_W:0] EMinX  = EMIN[EXP_W:0];
  localparam logic [6:0]            EMinLo = EMIN[6:0];

  logic             s1_valid_q, s1_valid_d;
  logic [127:0]     s1_mant_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic             s1_sign_q;

  logic             s2_valid_q, s2_valid_d;
  logic [127:0]     s2_mant_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic             s2_sign_q;
  logic             s2_zero_q;
  logic [6:0]       s2_shamt_q;

  logic s1_adv, s2_adv;
  logic s1_ld, s2_ld;

  logic [6:0] lz_idx;
  logic       lz_any;
  logic [6:0] shamt;
  logic [6:0] shamt_eff;
  logic [6:0] room;

  logic signed [EXP_W:0] exp_x;
  logic signed [EXP_W:0] diff_x;

  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;

  assign s1_ld = in_valid & in_ready & ~flush;
  assign s2_ld = s1_valid_q & s2_adv & ~flush;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s1_adv) s1_valid_d = in_valid;
      if (s2_adv) s2_valid_d = s1_valid_q;
    end
  end

  lzc_128 u_lzc (
    .a_i     (s1_mant_q),
    .idx_o   (lz_idx),
    .valid_o (lz_any)
  );

  assign shamt  = 7'd127 - lz_idx;
  assign exp_x  = {s1_exp_q[EXP_W-1], s1_exp_q};
  assign diff_x = exp_x - $signed({{(EXP_W-6){1'b0}}, shamt});
  // Low bits suffice: when clamping, exp - EMIN is below shamt <= 127.
  assign room   = s1_exp_q[6:0] - EMinLo;

  always_comb begin
    shamt_eff = shamt;
    if (ClampEn && (diff_x < EMinX)) begin
      shamt_eff = (exp_x > EMinX) ? room : 7'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mant_q  <= '0;
      s1_exp_q   <= '0;
      s1_sign_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_ld) begin
        s1_mant_q <= in_mant;
        s1_exp_q  <= in_exp;
        s1_sign_q <= in_sign;
      end
    end
  end

  // Zero entries register exp=0 and shamt=0 so the output needs no mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_mant_q  <= '0;
      s2_exp_q   <= '0;
      s2_sign_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_shamt_q <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_ld) begin
        s2_mant_q  <= s1_mant_q;
        s2_exp_q   <= lz_any ? s1_exp_q : '0;
        s2_sign_q  <= s1_sign_q;
        s2_zero_q  <= ~lz_any;
        s2_shamt_q <= lz_any ? shamt_eff : 7'd0;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_mant  = s2_mant_q << s2_shamt_q;
  assign out_exp   = s2_exp_q - {{(EXP_W-7){1'b0}}, s2_shamt_q};
  assign out_sign  = s2_sign_q;
  assign out_zero  = s2_zero_q;

endmodule
